// File: rtl/parking_gate_ctrl.sv
// Shared-lot parking controller: university/ordinary car counts, time-of-day
// reservation schedule, request/ack entry and exit handling, reject counter.
module parking_gate_ctrl #(
    parameter int unsigned TOTAL_CAP   = 700,
    parameter int unsigned UNI_CAP_DAY = 500,
    parameter int unsigned DAY_START   = 480,
    parameter int unsigned RAMP_START  = 780,
    parameter int unsigned RAMP_STEP   = 50,
    parameter int unsigned RAMP_PERIOD = 60,
    parameter int unsigned DAY_END     = 960,
    parameter int unsigned CW          = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          min_tick,
    input  logic          time_set,
    input  logic [10:0]   time_val,
    input  logic          ent_req,
    input  logic          ent_uni,
    input  logic          ext_req,
    input  logic          ext_uni,
    output logic          ent_ack,
    output logic          ent_ok,
    output logic          ext_ack,
    output logic          ext_ok,
    output logic [CW-1:0] uni_parked,
    output logic [CW-1:0] ord_parked,
    output logic [CW-1:0] uni_free,
    output logic [CW-1:0] ord_free,
    output logic          uni_avail,
    output logic          ord_avail,
    output logic [15:0]   reject_cnt,
    output logic [10:0]   time_min
);

    localparam logic [10:0] LAST_MIN = 11'd1439;

    // University reservation for the given minute of day.
    function automatic logic [CW-1:0] resv_f(input logic [10:0] t);
        int unsigned tt;
        int unsigned rel;
        tt = 32'(t);
        if (tt < DAY_START || tt >= DAY_END) return '0;
        if (tt < RAMP_START) return CW'(UNI_CAP_DAY);
        rel = RAMP_STEP * ((tt - RAMP_START) / RAMP_PERIOD + 1);
        return (rel >= UNI_CAP_DAY) ? '0 : CW'(UNI_CAP_DAY - rel);
    endfunction

    // Ordinary space: whatever the larger of reservation and uni occupancy leaves.
    function automatic logic [CW-1:0] ord_free_f(input logic [CW-1:0] r,
                                                 input logic [CW-1:0] u,
                                                 input logic [CW-1:0] o);
        int unsigned occ;
        int unsigned cap;
        occ = (r > u) ? 32'(r) : 32'(u);
        cap = (TOTAL_CAP > occ) ? TOTAL_CAP - occ : 0;
        return (cap > 32'(o)) ? CW'(cap - 32'(o)) : '0;
    endfunction

    function automatic logic [CW-1:0] uni_free_f(input logic [CW-1:0] u,
                                                 input logic [CW-1:0] o);
        int unsigned used;
        used = 32'(u) + 32'(o);
        return (TOTAL_CAP > used) ? CW'(TOTAL_CAP - used) : '0;
    endfunction

    logic [CW-1:0] uni_q, uni_d, ord_q, ord_d;
    logic [15:0]   rej_q, rej_d;
    logic [10:0]   time_q, time_d;
    logic          ent_ack_q, ent_ack_d, ent_ok_q, ent_ok_d;
    logic          ext_ack_q, ext_ack_d, ext_ok_q, ext_ok_d;
    logic [CW-1:0] resv, uni_x, ord_x;

    always_comb begin
        resv      = resv_f(time_q);
        uni_x     = uni_q;
        ord_x     = ord_q;
        ext_ack_d = ext_req;
        ext_ok_d  = 1'b0;
        ent_ack_d = ent_req;
        ent_ok_d  = 1'b0;
        rej_d     = rej_q;
        time_d    = time_q;

        if (ext_req) begin
            if (ext_uni && uni_q != '0) begin
                uni_x    = uni_q - CW'(1);
                ext_ok_d = 1'b1;
            end else if (!ext_uni && ord_q != '0) begin
                ord_x    = ord_q - CW'(1);
                ext_ok_d = 1'b1;
            end
        end

        // Entry sees post-exit counts so a same-cycle exit frees its space.
        uni_d = uni_x;
        ord_d = ord_x;
        if (ent_req) begin
            if (ent_uni && uni_free_f(uni_x, ord_x) != '0) begin
                uni_d    = uni_x + CW'(1);
                ent_ok_d = 1'b1;
            end else if (!ent_uni && ord_free_f(resv, uni_x, ord_x) != '0) begin
                ord_d    = ord_x + CW'(1);
                ent_ok_d = 1'b1;
            end else if (rej_q != 16'hFFFF) begin
                rej_d = rej_q + 16'd1;
            end
        end

        if (time_set)
            time_d = (time_val > LAST_MIN) ? LAST_MIN : time_val;
        else if (min_tick)
            time_d = (time_q == LAST_MIN) ? 11'd0 : time_q + 11'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uni_q     <= '0;
            ord_q     <= '0;
            rej_q     <= '0;
            time_q    <= '0;
            ent_ack_q <= 1'b0;
            ent_ok_q  <= 1'b0;
            ext_ack_q <= 1'b0;
            ext_ok_q  <= 1'b0;
        end else begin
            uni_q     <= uni_d;
            ord_q     <= ord_d;
            rej_q     <= rej_d;
            time_q    <= time_d;
            ent_ack_q <= ent_ack_d;
            ent_ok_q  <= ent_ok_d;
            ext_ack_q <= ext_ack_d;
            ext_ok_q  <= ext_ok_d;
        end
    end

    assign ent_ack    = ent_ack_q;
    assign ent_ok     = ent_ok_q;
    assign ext_ack    = ext_ack_q;
    assign ext_ok     = ext_ok_q;
    assign uni_parked = uni_q;
    assign ord_parked = ord_q;
    assign uni_free   = uni_free_f(uni_q, ord_q);
    assign ord_free   = ord_free_f(resv, uni_q, ord_q);
    assign uni_avail  = (uni_free != '0);
    assign ord_avail  = (ord_free != '0);
    assign reject_cnt = rej_q;
    assign time_min   = time_q;

endmodule
